// File: rtl/dmem_responder.sv
// dmem_responder: RV32I data-memory slave with a request/response handshake and programmable wait states.
// Each access is checked for funct3 legality, alignment and range; an access that errors leaves memory untouched.
module dmem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_32  = 32'(DEPTH);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  count;
   logic [3:0]  count_next;
   logic        enter_resp;
   logic        accept;

   logic        lat_write;
   logic [2:0]  lat_funct3;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        acc_write;
   logic [2:0]  acc_funct3;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;

   logic        funct3_ok;
   logic        misaligned;
   logic        out_of_range;
   logic        acc_err;

   logic [AW-1:0] word_idx;
   logic [31:0]   rd_word;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   load_data;
   logic [31:0]   store_data;
   logic [3:0]    byte_en;

   logic [31:0] mem [DEPTH];

   assign req_ready  = (state == IDLE) && rst_n;
   assign resp_valid = (state == RESP);
   assign accept     = req_valid && req_ready;

   // With zero wait states the access resolves on the accept edge itself, so it must see the live request.
   always_comb begin
      if (state == IDLE) begin
         acc_write  = req_write;
         acc_funct3 = req_funct3;
         acc_addr   = req_addr;
         acc_wdata  = req_wdata;
      end else begin
         acc_write  = lat_write;
         acc_funct3 = lat_funct3;
         acc_addr   = lat_addr;
         acc_wdata  = lat_wdata;
      end
   end

   always_comb begin
      funct3_ok  = 1'b0;
      misaligned = 1'b0;
      case (acc_funct3)
         3'b000: funct3_ok = 1'b1;
         3'b001: begin
            funct3_ok  = 1'b1;
            misaligned = acc_addr[0];
         end
         3'b010: begin
            funct3_ok  = 1'b1;
            misaligned = |acc_addr[1:0];
         end
         3'b100: funct3_ok = !acc_write;
         3'b101: begin
            funct3_ok  = !acc_write;
            misaligned = acc_addr[0];
         end
         default: funct3_ok = 1'b0;
      endcase
      out_of_range = ({2'b00, acc_addr[31:2]} >= DEPTH_32);
      acc_err      = !funct3_ok || misaligned || out_of_range;
   end

   assign word_idx = acc_addr[AW+1:2];
   assign rd_word  = mem[word_idx];

   always_comb begin
      case (acc_addr[1:0])
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (acc_funct3)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, rd_byte};
         3'b101:  load_data = {16'd0, rd_half};
         default: load_data = 32'd0;
      endcase
   end

   // Store data is replicated across lanes so the byte enables alone pick what lands in memory.
   always_comb begin
      case (acc_funct3[1:0])
         2'b00: begin
            byte_en    = 4'b0001 << acc_addr[1:0];
            store_data = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            byte_en    = acc_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{acc_wdata[15:0]}};
         end
         default: begin
            byte_en    = 4'b1111;
            store_data = acc_wdata;
         end
      endcase
   end

   always_comb begin
      state_next = state;
      count_next = count;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES > 0) begin
                  state_next = WAIT;
                  count_next = WAIT_LOAD;
               end else begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         WAIT: begin
            if (count == 4'd0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end else begin
               count_next = count - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_write  <= 1'b0;
         lat_funct3 <= 3'd0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
      end else if (accept) begin
         lat_write  <= req_write;
         lat_funct3 <= req_funct3;
         lat_addr   <= req_addr;
         lat_wdata  <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else if (enter_resp) begin
         resp_err   <= acc_err;
         resp_rdata <= (acc_err || acc_write) ? 32'd0 : load_data;
      end
   end

   // The array is deliberately left out of reset; only legal stores touch it.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_write && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
               mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words in the data array.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, range 0..15, meaning the wait states inserted before each response.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  meaning reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  input  1  meaning a request is presented.
REQ-006 The block SHALL have port req_ready  output  1  meaning the block accepts a request this cycle.
REQ-007 The block SHALL have port req_write  input  1  meaning store when 1, load when 0 (driven from the core's dmem_write).
REQ-008 The block SHALL have port req_funct3  input  3  meaning access size and sign per RV32I load/store funct3.
REQ-009 The block SHALL have port req_addr  input  32  meaning byte address.
REQ-010 The block SHALL have port req_wdata  input  32  meaning store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  meaning a response is presented.
REQ-012 The block SHALL have port resp_ready  input  1  meaning the core consumes the response.
REQ-013 The block SHALL have port resp_rdata  output  32  meaning load result, extended to 32 bits.
REQ-014 The block SHALL have port resp_err  output  1  meaning the access was misaligned, out of range, or had an illegal funct3.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 IDLE: on req_valid, latch write, funct3, addr, wdata; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 WAIT: a 4-bit counter SHALL load WAIT_CYCLES-1 on entry and decrement each cycle; go to RESP when it is 0.
REQ-018 Latency from the accept edge to the first resp_valid cycle SHALL be WAIT_CYCLES+1 clocks.
REQ-019 RESP: resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1; that edge returns to IDLE.
REQ-020 No new request SHALL be accepted in the cycle resp_ready completes a response; the earliest accept is the following cycle.
REQ-021 Legal funct3 SHALL be 000 (byte), 001 (half), 010 (word), and for loads only 100 (byte unsigned) and 101 (half unsigned); all others set resp_err.
REQ-022 Misalignment (half with addr[0]=1; word with addr[1:0]!=0) SHALL set resp_err.
REQ-023 An out-of-range access (addr[31:2] >= DEPTH) SHALL set resp_err.
REQ-024 An erroring access SHALL NOT modify memory and SHALL return resp_rdata=0.
REQ-025 A store SHALL write only the addressed bytes (byte lane addr[1:0], half lane addr[1]) on the edge leaving WAIT/IDLE into RESP; resp_rdata=0 for stores.
REQ-026 A load SHALL read the word on entry to RESP, select the lane, and sign-extend (000, 001) or zero-extend (100, 101).
REQ-027 Memory is little-endian: byte 0 is bits 7:0.
REQ-028 req_valid held while not ready SHALL be ignored until IDLE; the block SHALL NOT drop a request presented in IDLE.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0, and req_ready=1 after release.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 Reset in WAIT SHALL abort the access with no memory write; reset in RESP discards the response.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid exactly 3 clocks after each accept (WAIT_CYCLES=2).
REQ-033 SB 0x80 @0x11 over 0x00000000, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0x00008000.
REQ-034 LH @0x13 and SW @0x12 -> resp_err=1, resp_rdata=0; a following LW @0x10 shows the word unchanged.
REQ-035 LW @0x400 with DEPTH=256 -> resp_err=1; funct3=011 -> resp_err=1; SW with funct3=100 -> resp_err=1, no write.
REQ-036 Hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0; on release, the next accept occurs no earlier than 1 cycle later.
REQ-037 Assert rst_n=0 mid-WAIT of SW 0x12345678 @0x20 -> all outputs 0 immediately; a later LW @0x20 returns the prior value.
